// File: rtl/parking_lot_controller_if.sv
// Bus between the bay sensors / entry gate and the parking lot controller.
interface parking_lot_controller_if #(
  parameter int NUM_SPACES = 8
);
  localparam int CW = $clog2(NUM_SPACES + 1);

  logic [NUM_SPACES-1:0] sensors;
  logic                  entry_req;
  logic                  entry_clear;
  logic [NUM_SPACES-1:0] parking_spaces;
  logic [CW-1:0]         occupied_count;
  logic                  lot_full;
  logic                  lot_empty;
  logic                  gate_open;
  logic                  entry_denied;

  modport master (
    output sensors, entry_req, entry_clear,
    input  parking_spaces, occupied_count, lot_full, lot_empty, gate_open, entry_denied
  );

  modport slave (
    input  sensors, entry_req, entry_clear,
    output parking_spaces, occupied_count, lot_full, lot_empty, gate_open, entry_denied
  );
endinterface

// File: rtl/parking_lot_controller.sv
// Parking lot controller: debounced bay occupancy, occupancy count/flags and
// an entry-gate state machine that grants or refuses entry based on lot_full.
module parking_lot_controller #(
  parameter int NUM_SPACES      = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GATE_TIMEOUT    = 16
) (
  input logic                     clk,
  input logic                     rst,
  parking_lot_controller_if.slave bus
);
  localparam int CW = $clog2(NUM_SPACES + 1);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW = (GATE_TIMEOUT > 1) ? $clog2(GATE_TIMEOUT) : 1;

  typedef enum logic {IDLE, OPEN} state_t;

  logic [NUM_SPACES-1:0] sync1, sync2, stable, stable_next;
  logic [DW-1:0]         cnt      [NUM_SPACES];
  logic [DW-1:0]         cnt_next [NUM_SPACES];
  logic [CW-1:0]         count_q, count_next;
  logic                  full_q, empty_q;

  state_t                state;
  logic [TW-1:0]         timer;
  logic [TW-1:0]         deny_cnt;
  logic                  gate_q, denied_q;

  assign bus.parking_spaces = stable;
  assign bus.occupied_count = count_q;
  assign bus.lot_full       = full_q;
  assign bus.lot_empty      = empty_q;
  assign bus.gate_open      = gate_q;
  assign bus.entry_denied   = denied_q;

  // Per-bay debounce next state, plus popcount of the next occupancy vector so
  // the count and flags update on the same edge as parking_spaces.
  always_comb begin
    stable_next = stable;
    count_next  = '0;
    for (int unsigned i = 0; i < NUM_SPACES; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1))
          stable_next[i] = sync2[i];
        else
          cnt_next[i] = cnt[i] + DW'(1);
      end
    end
    for (int unsigned i = 0; i < NUM_SPACES; i++)
      count_next = count_next + CW'(stable_next[i]);
  end

  // Synchronisers, debounce state, occupancy vector and registered count/flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      stable  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      for (int unsigned i = 0; i < NUM_SPACES; i++)
        cnt[i] <= '0;
    end else begin
      sync1   <= bus.sensors;
      sync2   <= sync1;
      stable  <= stable_next;
      count_q <= count_next;
      full_q  <= (count_next == CW'(NUM_SPACES));
      empty_q <= (count_next == '0);
      for (int unsigned i = 0; i < NUM_SPACES; i++)
        cnt[i] <= cnt_next[i];
    end
  end

  // Entry gate FSM with open timeout and a denial timer that re-pulses
  // entry_denied every GATE_TIMEOUT cycles while a request waits on a full lot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      deny_cnt <= '0;
      gate_q   <= 1'b0;
      denied_q <= 1'b0;
    end else begin
      denied_q <= 1'b0;
      unique case (state)
        IDLE: begin
          timer <= '0;
          if (bus.entry_req && !full_q) begin
            state    <= OPEN;
            gate_q   <= 1'b1;
            deny_cnt <= '0;
          end else if (bus.entry_req) begin
            denied_q <= (deny_cnt == '0);
            deny_cnt <= (deny_cnt == TW'(GATE_TIMEOUT - 1)) ? '0 : deny_cnt + TW'(1);
          end else begin
            deny_cnt <= '0;
          end
        end
        OPEN: begin
          deny_cnt <= '0;
          if (bus.entry_clear || timer == TW'(GATE_TIMEOUT - 1)) begin
            state  <= IDLE;
            gate_q <= 1'b0;
            timer  <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_parking_lot_controller.sv
// Scoreboard bench for parking_lot_controller: stimulus queues expected output
// snapshots tagged with an edge number, a monitor compares them at the negedge.
module tb_parking_lot_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  parking_lot_controller_if #(.NUM_SPACES(8)) bus ();

  parking_lot_controller #(
    .NUM_SPACES(8),
    .DEBOUNCE_CYCLES(4),
    .GATE_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // v = {parking_spaces, occupied_count, lot_full, lot_empty, gate_open, entry_denied}
  typedef struct {
    int          at;
    string       nm;
    logic [15:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic [15:0] got;

  task automatic push(input int at, input string nm, input logic [7:0] ps, input int cnt,
                      input logic full, input logic empty, input logic gate, input logic den);
    exp_t e;
    e.at = at;
    e.nm = nm;
    e.v  = {ps, 4'(cnt), full, empty, gate, den};
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= edge_n) begin
      cur = sb.pop_front();
      checks++;
      got = {bus.parking_spaces, bus.occupied_count, bus.lot_full, bus.lot_empty,
             bus.gate_open, bus.entry_denied};
      if (cur.at < edge_n) begin
        errors++;
        $display("FAIL %s: expectation for edge %0d not reached in time (now %0d)",
                 cur.nm, cur.at, edge_n);
      end else if (got !== cur.v) begin
        errors++;
        $display("FAIL %s @edge %0d: got ps=%h cnt=%0d full=%b empty=%b gate=%b den=%b, exp ps=%h cnt=%0d full=%b empty=%b gate=%b den=%b",
                 cur.nm, edge_n, got[15:8], got[7:4], got[3], got[2], got[1], got[0],
                 cur.v[15:8], cur.v[7:4], cur.v[3], cur.v[2], cur.v[1], cur.v[0]);
      end
    end
  end

  initial begin
    int e0;
    bus.sensors     = 8'h00;
    bus.entry_req   = 1'b0;
    bus.entry_clear = 1'b0;

    // reset state
    step(2);
    push(edge_n, "reset", 8'h00, 0, 0, 1, 0, 0);
    rst = 1'b0;
    step(1);

    // single bay, DEBOUNCE_CYCLES+2 edge latency
    e0 = edge_n;
    bus.sensors = 8'h01;
    push(e0 + 5, "t1_before", 8'h00, 0, 0, 1, 0, 0);
    push(e0 + 6, "t1_set",    8'h01, 1, 0, 0, 0, 0);
    step(6);

    // 3-cycle glitch on bay 4 is filtered
    e0 = edge_n;
    bus.sensors = 8'h09;
    push(e0 + 6, "t2_glitch6", 8'h01, 1, 0, 0, 0, 0);
    push(e0 + 8, "t2_glitch8", 8'h01, 1, 0, 0, 0, 0);
    step(3);
    bus.sensors = 8'h01;
    step(8);

    // 4-cycle pulse is accepted, then released 6 edges after the release
    e0 = edge_n;
    bus.sensors = 8'h09;
    push(e0 + 5,  "t2_pulse_pre",  8'h01, 1, 0, 0, 0, 0);
    push(e0 + 6,  "t2_pulse_set",  8'h09, 2, 0, 0, 0, 0);
    push(e0 + 9,  "t2_pulse_hold", 8'h09, 2, 0, 0, 0, 0);
    push(e0 + 10, "t2_pulse_clr",  8'h01, 1, 0, 0, 0, 0);
    step(4);
    bus.sensors = 8'h01;
    step(8);

    // all bays at once -> full; request is denied, denial re-pulses after 16
    e0 = edge_n;
    bus.sensors = 8'hFF;
    push(e0 + 5, "t3_pre",  8'h01, 1, 0, 0, 0, 0);
    push(e0 + 6, "t3_full", 8'hFF, 8, 1, 0, 0, 0);
    step(6);
    e0 = edge_n;
    bus.entry_req = 1'b1;
    push(e0 + 1,  "t3_deny",      8'hFF, 8, 1, 0, 0, 1);
    push(e0 + 2,  "t3_deny_off",  8'hFF, 8, 1, 0, 0, 0);
    push(e0 + 16, "t3_deny_wait", 8'hFF, 8, 1, 0, 0, 0);
    push(e0 + 17, "t3_deny_rep",  8'hFF, 8, 1, 0, 0, 1);
    step(18);
    bus.entry_req = 1'b0;

    // partial occupancy, open then close on entry_clear
    e0 = edge_n;
    bus.sensors = 8'h55;
    push(e0 + 5, "t4_pre", 8'hFF, 8, 1, 0, 0, 0);
    push(e0 + 6, "t4_55",  8'h55, 4, 0, 0, 0, 0);
    step(6);
    e0 = edge_n;
    bus.entry_req = 1'b1;
    push(e0 + 1, "t4_open",   8'h55, 4, 0, 0, 1, 0);
    push(e0 + 6, "t4_held",   8'h55, 4, 0, 0, 1, 0);
    push(e0 + 7, "t4_closed", 8'h55, 4, 0, 0, 0, 0);
    step(1);
    bus.entry_req = 1'b0;
    step(5);
    bus.entry_clear = 1'b1;
    step(1);
    bus.entry_clear = 1'b0;
    step(2);

    // timeout close after exactly 16 cycles open
    e0 = edge_n;
    bus.entry_req = 1'b1;
    push(e0 + 1,  "t5_open",  8'h55, 4, 0, 0, 1, 0);
    push(e0 + 16, "t5_last",  8'h55, 4, 0, 0, 1, 0);
    push(e0 + 17, "t5_close", 8'h55, 4, 0, 0, 0, 0);
    step(1);
    bus.entry_req = 1'b0;
    step(18);

    // async reset while OPEN, then recovery with 8'hAA
    e0 = edge_n;
    bus.sensors   = 8'hAA;
    bus.entry_req = 1'b1;
    push(e0 + 3, "t6_open", 8'h55, 4, 0, 0, 1, 0);
    step(1);
    bus.entry_req = 1'b0;
    step(3);
    rst = 1'b1;
    push(edge_n, "t6_async_rst", 8'h00, 0, 0, 1, 0, 0);
    step(2);
    rst = 1'b0;
    e0 = edge_n;
    push(e0 + 5, "t6_pre", 8'h00, 0, 0, 1, 0, 0);
    push(e0 + 6, "t6_AA",  8'hAA, 4, 0, 0, 0, 0);
    step(8);

    for (int i = 0; i < 8 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations never compared", sb.size());
      checks += sb.size();
      errors += sb.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
